// File: rtl/prog_loader.sv
// Framed program downloader: turns a UART byte stream into single-byte memory
// writes and holds the CPU in reset while a frame is in flight.
module prog_loader #(
  parameter logic [7:0] SYNC_BYTE      = 8'h55,
  parameter int         TIMEOUT_CYCLES = 5_000_000,
  parameter int         TO_W           = 23
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_LEN,
    S_DATA,
    S_CHK
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state_reg;
  logic [15:0]     addr_reg;
  logic [8:0]      count_reg;
  logic [7:0]      sum_reg;
  logic [TO_W-1:0] to_cnt_reg;
  logic            hold_reg;
  logic [7:0]      chk_sum;

  // Running sum including the byte currently on the bus; zero means a good frame.
  assign chk_sum  = sum_reg + rx_data;
  assign busy     = hold_reg;
  assign cpu_hold = hold_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      addr_reg   <= '0;
      count_reg  <= '0;
      sum_reg    <= '0;
      to_cnt_reg <= '0;
      hold_reg   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      // A byte arriving on the expiry cycle takes priority over the timeout.
      if (rx_valid) begin
        to_cnt_reg <= '0;
        case (state_reg)
          S_IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              state_reg <= S_ADDR_HI;
              hold_reg  <= 1'b1;
              sum_reg   <= '0;
            end
          end
          S_ADDR_HI: begin
            addr_reg[15:8] <= rx_data;
            sum_reg        <= chk_sum;
            state_reg      <= S_ADDR_LO;
          end
          S_ADDR_LO: begin
            addr_reg[7:0] <= rx_data;
            sum_reg       <= chk_sum;
            state_reg     <= S_LEN;
          end
          S_LEN: begin
            count_reg <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
            sum_reg   <= chk_sum;
            state_reg <= S_DATA;
          end
          S_DATA: begin
            mem_addr  <= addr_reg;
            mem_wdata <= rx_data;
            mem_we    <= 1'b1;
            addr_reg  <= addr_reg + 16'd1;
            sum_reg   <= chk_sum;
            count_reg <= count_reg - 9'd1;
            if (count_reg == 9'd1) begin
              state_reg <= S_CHK;
            end
          end
          S_CHK: begin
            if (chk_sum == 8'h00) begin
              done <= 1'b1;
            end else begin
              err      <= 1'b1;
              err_code <= 2'b01;
            end
            state_reg <= S_IDLE;
            hold_reg  <= 1'b0;
          end
          default: begin
            state_reg <= S_IDLE;
            hold_reg  <= 1'b0;
          end
        endcase
      end else if (state_reg != S_IDLE) begin
        if (to_cnt_reg == TO_LAST) begin
          err        <= 1'b1;
          err_code   <= 2'b10;
          state_reg  <= S_IDLE;
          hold_reg   <= 1'b0;
          to_cnt_reg <= '0;
        end else begin
          to_cnt_reg <= to_cnt_reg + TO_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of known frames, hand-built corner sequences,
// then random frames checked against a frame-level reference model.
module tb_prog_loader;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  prog_loader #(.SYNC_BYTE(8'h55), .TIMEOUT_CYCLES(TO), .TO_W(6)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [23:0] wq[$];
  logic [23:0] exp_w[$];
  logic [7:0]  fq[$];
  int          done_cnt = 0;
  int          err_cnt = 0;
  logic [1:0]  code_seen = 2'b00;
  logic        prev_we = 1'b0;
  logic        rx_s;

  // Observer: collects writes and pulses; a write must follow the byte sampled on the same edge.
  always @(posedge clk) begin
    rx_s = rx_valid;
    #1;
    if (mem_we) begin
      wq.push_back({mem_addr, mem_wdata});
      tests++;
      if (!rx_s || prev_we) begin
        fails++;
        $display("FAIL we_timing: we=%0b rx_sampled=%0b prev_we=%0b required rx_sampled=1 prev_we=0",
                 mem_we, rx_s, prev_we);
      end
    end
    if (done) done_cnt++;
    if (err) begin
      err_cnt++;
      code_seen = err_code;
    end
    prev_we = mem_we;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    wq.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  // Called at a negedge; byte is sampled on the next posedge, returns at following negedge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input bit complete, input int gmin, input int gmax);
    bit   hold_ok;
    logic exp_h;
    hold_ok = 1'b1;
    for (int i = 0; i < fq.size(); i++) begin
      send_byte(fq[i], 0);
      exp_h = !(complete && (i == fq.size() - 1));
      if (busy !== exp_h || cpu_hold !== exp_h) hold_ok = 1'b0;
      repeat ($urandom_range(gmax, gmin)) @(negedge clk);
    end
    check("hold_window", {31'd0, hold_ok}, 32'd1);
  endtask

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [7:0]  len;
    logic [31:0] d;
    logic [7:0]  chk;
    int          nw;
    logic [15:0] last_a;
    logic [7:0]  last_d;
    logic        ok;
    logic [1:0]  code;
  } vec_t;

  vec_t vt[7];

  initial begin
    logic [31:0] tmp;
    logic [15:0] a16;
    logic [7:0]  b8;
    logic [7:0]  s;
    logic [7:0]  chk;
    logic [15:0] base;
    logic [7:0]  len;
    int          n, keep, nn;
    bit          trunc, bad, seq_ok;

    vt[0] = '{8'hC0, 8'h00, 8'h02, 32'hA9FF0000, 8'h96, 2,   16'hC001, 8'hFF, 1'b1, 2'b00};
    vt[1] = '{8'hC0, 8'h00, 8'h02, 32'hA9FF0000, 8'h97, 2,   16'hC001, 8'hFF, 1'b0, 2'b01};
    vt[2] = '{8'hFF, 8'hFF, 8'h01, 32'h11000000, 8'hF0, 1,   16'hFFFF, 8'h11, 1'b1, 2'b00};
    vt[3] = '{8'hFF, 8'hFF, 8'h01, 32'h11000000, 8'hF1, 1,   16'hFFFF, 8'h11, 1'b0, 2'b01};
    vt[4] = '{8'h00, 8'h00, 8'h00, 32'h00000000, 8'h80, 256, 16'h00FF, 8'hFF, 1'b1, 2'b00};
    vt[5] = '{8'hFF, 8'hFE, 8'h03, 32'h01020300, 8'hFA, 3,   16'h0000, 8'h03, 1'b1, 2'b00};
    vt[6] = '{8'h12, 8'h34, 8'h02, 32'h55550000, 8'h0E, 2,   16'h1235, 8'h55, 1'b1, 2'b00};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    check("rst_flags", {26'd0, mem_we, cpu_hold, busy, done, err, 1'b0}, 32'd0);
    check("rst_err_code", {30'd0, err_code}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy_after", {31'd0, busy}, 32'd0);

    // Noise in IDLE, then a sync byte starts a frame
    clear_obs();
    send_byte(8'h00, 1);
    send_byte(8'hAA, 1);
    send_byte(8'h54, 1);
    check("noise_busy", {31'd0, busy}, 32'd0);
    check("noise_writes", wq.size(), 32'd0);
    send_byte(8'h55, 0);
    check("sync_busy", {30'd0, busy, cpu_hold}, 32'd3);
    @(negedge clk);

    // Reset during DATA right after the first write strobe
    send_byte(8'hC0, 1);
    send_byte(8'h00, 1);
    send_byte(8'h02, 1);
    send_byte(8'hA9, 0);
    check("pre_rst_we", {31'd0, mem_we}, 32'd1);
    check("pre_rst_addr", {8'd0, mem_addr, mem_wdata}, 32'hC000A9);
    #2 reset = 1'b1;
    #1;
    check("midrst_flags", {27'd0, mem_we, cpu_hold, busy, done, err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_pulses", done_cnt + err_cnt, 32'd0);

    // Table of known frames (first row doubles as the fresh frame after reset)
    for (int v = 0; v < 7; v++) begin
      clear_obs();
      fq.delete();
      fq.push_back(8'h55);
      fq.push_back(vt[v].hi);
      fq.push_back(vt[v].lo);
      fq.push_back(vt[v].len);
      if (vt[v].len == 8'h00) begin
        for (int j = 0; j < 256; j++) fq.push_back(8'(j));
      end else begin
        for (int j = 0; j < int'(vt[v].len); j++) begin
          tmp = vt[v].d >> (24 - 8 * j);
          fq.push_back(tmp[7:0]);
        end
      end
      fq.push_back(vt[v].chk);
      send_frame(1'b1, 1, 1);
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d_nwrites", v), wq.size(), vt[v].nw);
      if (wq.size() > 0) begin
        check($sformatf("vec%0d_first_addr", v), {16'd0, wq[0][23:8]}, {16'd0, vt[v].hi, vt[v].lo});
        check($sformatf("vec%0d_last", v), {8'd0, wq[wq.size()-1]}, {8'd0, vt[v].last_a, vt[v].last_d});
      end
      seq_ok = 1'b1;
      for (int j = 1; j < wq.size(); j++) begin
        a16 = wq[j-1][23:8] + 16'd1;
        if (wq[j][23:8] !== a16) seq_ok = 1'b0;
      end
      check($sformatf("vec%0d_addr_seq", v), {31'd0, seq_ok}, 32'd1);
      check($sformatf("vec%0d_done", v), done_cnt, vt[v].ok ? 32'd1 : 32'd0);
      check($sformatf("vec%0d_err", v), err_cnt, vt[v].ok ? 32'd0 : 32'd1);
      if (!vt[v].ok) check($sformatf("vec%0d_code", v), {30'd0, code_seen}, {30'd0, vt[v].code});
      $display("[TB] vector %0d: writes=%0d done=%0d err=%0d", v, wq.size(), done_cnt, err_cnt);
    end

    // Timeout after 55 C0
    clear_obs();
    send_byte(8'h55, 1);
    send_byte(8'hC0, 0);
    repeat (TO - 1) @(negedge clk);
    check("to_before", {30'd0, busy, err}, 32'd2);
    @(negedge clk);
    check("to_fire", {27'd0, err, err_code, busy, cpu_hold}, 32'b1_10_00);
    @(negedge clk);
    check("to_pulse_once", {31'd0, err}, 32'd0);
    check("to_err_cnt", err_cnt, 32'd1);
    $display("[TB] timeout frame: err_cnt=%0d code=%0b", err_cnt, code_seen);

    // Byte landing on the expiry cycle continues the frame
    clear_obs();
    send_byte(8'h55, 1);
    send_byte(8'hC0, 0);
    repeat (TO - 1) @(negedge clk);
    send_byte(8'h00, 0);
    check("expiry_byte_wins", {30'd0, busy, err}, 32'd2);
    @(negedge clk);
    send_byte(8'h01, 1);
    send_byte(8'h77, 1);
    send_byte(8'hC8, 1);
    repeat (2) @(negedge clk);
    check("expiry_pulses", {done_cnt[15:0], err_cnt[15:0]}, 32'h0001_0000);
    check("expiry_nwrites", wq.size(), 32'd1);
    if (wq.size() > 0) check("expiry_write", {8'd0, wq[0]}, 32'hC00077);
    check("err_code_holds", {30'd0, err_code}, 32'd2);
    $display("[TB] expiry frame: writes=%0d done=%0d", wq.size(), done_cnt);

    // Random frames against a frame-level model
    for (int f = 0; f < 40; f++) begin
      clear_obs();
      nn = $urandom_range(2, 0);
      for (int k = 0; k < nn; k++) begin
        b8 = 8'($urandom_range(255, 0));
        if (b8 == 8'h55) b8 = 8'h54;
        send_byte(b8, $urandom_range(3, 1));
      end
      check($sformatf("rnd%0d_noise_idle", f), {31'd0, busy}, 32'd0);
      base  = 16'($urandom);
      len   = (f % 13 == 5) ? 8'h00 : 8'($urandom_range(8, 1));
      n     = (len == 8'h00) ? 256 : int'(len);
      trunc = ($urandom_range(7, 0) == 0);
      bad   = ($urandom_range(3, 0) == 0);
      keep  = trunc ? int'($urandom_range(n - 1, 0)) : n;
      fq.delete();
      exp_w.delete();
      fq.push_back(8'h55);
      fq.push_back(base[15:8]);
      fq.push_back(base[7:0]);
      fq.push_back(len);
      s = base[15:8] + base[7:0] + len;
      for (int j = 0; j < keep; j++) begin
        b8  = 8'($urandom);
        a16 = base + 16'(j);
        fq.push_back(b8);
        exp_w.push_back({a16, b8});
        s = s + b8;
      end
      if (!trunc) begin
        chk = 8'h00 - s;
        if (bad) chk = chk ^ 8'($urandom_range(255, 1));
        fq.push_back(chk);
      end
      send_frame(!trunc, 1, 3);
      if (trunc) repeat (TO + 5) @(negedge clk);
      else repeat (2) @(negedge clk);
      check($sformatf("rnd%0d_nwrites", f), wq.size(), exp_w.size());
      seq_ok = (wq.size() == exp_w.size());
      for (int j = 0; j < wq.size() && j < exp_w.size(); j++)
        if (wq[j] !== exp_w[j]) seq_ok = 1'b0;
      check($sformatf("rnd%0d_write_data", f), {31'd0, seq_ok}, 32'd1);
      check($sformatf("rnd%0d_done", f), done_cnt, (!trunc && !bad) ? 32'd1 : 32'd0);
      check($sformatf("rnd%0d_err", f), err_cnt, (trunc || bad) ? 32'd1 : 32'd0);
      if (trunc || bad) check($sformatf("rnd%0d_code", f), {30'd0, code_seen}, trunc ? 32'd2 : 32'd1);
      check($sformatf("rnd%0d_idle_after", f), {31'd0, busy}, 32'd0);
      $display("[TB] random frame %0d: base=%04h len=%0d trunc=%0b bad=%0b writes=%0d",
               f, base, n, trunc, bad, wq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
